// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the execute stage and the HI/LO sequencer.
// A request moves when req_valid && req_ready at a rising clk edge; the
// requester holds req_valid and its payload stable until then.
interface muldiv_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        flush;
   logic        busy;
   logic        hi_write;
   logic        lo_write;
   logic [31:0] hi_data;
   logic [31:0] lo_data;

   modport master (
      output req_valid, req_op, req_a, req_b, flush,
      input  req_ready, busy, hi_write, lo_write, hi_data, lo_data
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush,
      output req_ready, busy, hi_write, lo_write, hi_data, lo_data
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO update sequencer: latency-counted multiply, radix-2 restoring divide,
// and MTHI/MTLO, each ending in a one-cycle write strobe to the HI/LO file.
module muldiv_ctrl #(
   parameter int MUL_LAT  = 2,
   parameter int DIV_BITS = 32
) (
   input  logic          clk,
   input  logic          resetn,
   muldiv_ctrl_if.slave  bus,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam int         CNT_W    = 6;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        op_a;
   logic [31:0]        op_b;
   logic               is_signed;
   logic               neg_q;
   logic               neg_r;
   logic [32:0]        rem;
   logic [31:0]        quo;
   logic               hi_write_q;
   logic               lo_write_q;
   logic [31:0]        hi_data_q;
   logic [31:0]        lo_data_q;
   logic               busy_q;

   logic               op_known;
   logic               accept;
   logic               req_signed_div;
   logic [31:0]        abs_a;
   logic [31:0]        abs_b;
   logic [63:0]        ext_a;
   logic [63:0]        ext_b;
   logic [63:0]        product;
   logic [33:0]        shifted;
   logic [33:0]        trial;
   logic [32:0]        rem_next;
   logic [31:0]        quo_next;
   logic [31:0]        q_fix;
   logic [31:0]        r_fix;

   assign op_known       = (bus.req_op != 3'd0) && (bus.req_op != 3'd7);
   assign bus.req_ready  = (state == S_IDLE) && !bus.flush;
   assign accept         = bus.req_valid && bus.req_ready && op_known;
   assign req_signed_div = (bus.req_op == OP_DIV);

   // Operand magnitudes for the signed divide; 0x80000000 maps onto itself,
   // which is still the right unsigned magnitude.
   assign abs_a = (req_signed_div && bus.req_a[31]) ? (32'd0 - bus.req_a) : bus.req_a;
   assign abs_b = (req_signed_div && bus.req_b[31]) ? (32'd0 - bus.req_b) : bus.req_b;

   // Extending to 64 bits first lets one truncated multiply serve both
   // signed and unsigned products.
   assign ext_a   = {{32{is_signed & op_a[31]}}, op_a};
   assign ext_b   = {{32{is_signed & op_b[31]}}, op_b};
   assign product = ext_a * ext_b;

   // One restoring step; the partial remainder never exceeds the divisor, so
   // bit 33 of the trial difference is a reliable borrow.
   assign shifted  = {rem, quo[31]};
   assign trial    = shifted - {2'b00, op_b};
   assign rem_next = trial[33] ? shifted[32:0] : trial[32:0];
   assign quo_next = {quo[30:0], ~trial[33]};

   assign q_fix = neg_q ? (32'd0 - quo) : quo;
   assign r_fix = neg_r ? (32'd0 - rem[31:0]) : rem[31:0];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         cnt        <= '0;
         op_a       <= '0;
         op_b       <= '0;
         is_signed  <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         rem        <= '0;
         quo        <= '0;
         hi_write_q <= 1'b0;
         lo_write_q <= 1'b0;
         hi_data_q  <= '0;
         lo_data_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         hi_write_q <= 1'b0;
         lo_write_q <= 1'b0;
         if (bus.flush) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept) begin
                     case (bus.req_op)
                        OP_MTHI: begin
                           hi_write_q <= 1'b1;
                           hi_data_q  <= bus.req_a;
                           state      <= S_DONE;
                        end
                        OP_MTLO: begin
                           lo_write_q <= 1'b1;
                           lo_data_q  <= bus.req_a;
                           state      <= S_DONE;
                        end
                        OP_MULT, OP_MULTU: begin
                           op_a      <= bus.req_a;
                           op_b      <= bus.req_b;
                           is_signed <= (bus.req_op == OP_MULT);
                           cnt       <= CNT_W'(MUL_LAT);
                           busy_q    <= 1'b1;
                           state     <= S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                           op_b      <= abs_b;
                           quo       <= abs_a;
                           rem       <= '0;
                           is_signed <= req_signed_div;
                           neg_q     <= req_signed_div && (bus.req_a[31] ^ bus.req_b[31]);
                           neg_r     <= req_signed_div && bus.req_a[31];
                           cnt       <= CNT_W'(DIV_BITS);
                           busy_q    <= 1'b1;
                           state     <= S_DIV;
                        end
                        default: state <= S_IDLE;
                     endcase
                  end
               end
               S_MUL: begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) begin
                     hi_data_q  <= product[63:32];
                     lo_data_q  <= product[31:0];
                     hi_write_q <= 1'b1;
                     lo_write_q <= 1'b1;
                     busy_q     <= 1'b0;
                     state      <= S_DONE;
                  end
               end
               S_DIV: begin
                  rem <= rem_next;
                  quo <= quo_next;
                  cnt <= cnt - 1'b1;
                  if (cnt == CNT_W'(1)) begin
                     state <= S_FIX;
                  end
               end
               S_FIX: begin
                  lo_data_q  <= q_fix;
                  hi_data_q  <= r_fix;
                  hi_write_q <= 1'b1;
                  lo_write_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state      <= S_DONE;
               end
               S_DONE: begin
                  state <= S_IDLE;
               end
               default: begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
            endcase
         end
      end
   end

   // A squash that lands while the strobe is already on the wire must still
   // keep it out of the register file, hence the gate on flush.
   assign bus.hi_write = hi_write_q & ~bus.flush;
   assign bus.lo_write = lo_write_q & ~bus.flush;
   assign bus.hi_data  = hi_data_q;
   assign bus.lo_data  = lo_data_q;
   assign bus.busy     = busy_q;
   assign dbg_state    = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random
// operations scored against an arithmetic model of HI/LO results.
module tb_muldiv_ctrl;
   localparam int MUL_LAT  = 2;
   localparam int DIV_LAT  = 34;

   logic        clk;
   logic        resetn;
   logic [2:0]  dbg_state;
   int          n_cmp;
   int          n_err;
   logic [65:0] exp_q[$];

   muldiv_ctrl_if bus();

   muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_BITS(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Packs {hi_write, lo_write, hi, lo}.
   function automatic logic [65:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p, qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: begin p = sa * sb; return {2'b11, p}; end
         3'd2: begin p = {32'h0, a} * {32'h0, b}; return {2'b11, p}; end
         3'd3: begin
            if (b == 32'h0) return {2'b11, a, (a[31] ? 32'h1 : 32'hFFFF_FFFF)};
            q = sa / sb; r = sa % sb; qv = q; rv = r;
            return {2'b11, rv[31:0], qv[31:0]};
         end
         3'd4: begin
            if (b == 32'h0) return {2'b11, a, 32'hFFFF_FFFF};
            return {2'b11, a % b, a / b};
         end
         3'd5: return {2'b10, a, 32'h0};
         default: return {2'b01, 32'h0, a};
      endcase
   endfunction

   function automatic int latency(input logic [2:0] op);
      if (op == 3'd1 || op == 3'd2) return MUL_LAT + 1;
      if (op == 3'd3 || op == 3'd4) return DIV_LAT;
      return 1;
   endfunction

   // ---------------- driver / scoreboard tasks ----------------
   // Called right after the accepting edge; walks the op to its DONE cycle.
   task automatic expect_result(input int lat, input string name);
      logic [65:0] e;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.req_ready !== 1'b0) begin
            n_err++; $display("FAIL %s ready_busy k=%0d: got %b want 0", name, k, bus.req_ready);
         end
         if (k < lat) begin
            n_cmp++;
            if ({bus.hi_write, bus.lo_write} !== 2'b00) begin
               n_err++; $display("FAIL %s early_strobe k=%0d: got %b want 00", name, k,
                                 {bus.hi_write, bus.lo_write});
            end
            n_cmp++;
            if (bus.busy !== 1'b1) begin
               n_err++; $display("FAIL %s busy k=%0d: got %b want 1", name, k, bus.busy);
            end
         end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.hi_write, bus.lo_write} !== e[65:64]) begin
               n_err++; $display("FAIL %s strobes: got %b want %b", name,
                                 {bus.hi_write, bus.lo_write}, e[65:64]);
            end
            if (e[65]) begin
               n_cmp++;
               if (bus.hi_data !== e[63:32]) begin
                  n_err++; $display("FAIL %s hi: got %h want %h", name, bus.hi_data, e[63:32]);
               end
            end
            if (e[64]) begin
               n_cmp++;
               if (bus.lo_data !== e[31:0]) begin
                  n_err++; $display("FAIL %s lo: got %h want %h", name, bus.lo_data, e[31:0]);
               end
            end
         end
      end
   endtask

   task automatic expect_idle(input string name);
      @(negedge clk);
      n_cmp++;
      if ({bus.hi_write, bus.lo_write, bus.busy, bus.req_ready} !== 4'b0001) begin
         n_err++; $display("FAIL %s idle: got hw/lw/busy/rdy=%b want 0001", name,
                           {bus.hi_write, bus.lo_write, bus.busy, bus.req_ready});
      end
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
      int budget;
      budget = 0;
      while (bus.req_ready !== 1'b1 && budget < 50) begin
         @(negedge clk); budget++;
      end
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_err++; $display("FAIL %s ready_wait: got %b want 1", name, bus.req_ready);
      end
      exp_q.push_back(model(op, a, b));
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      expect_result(latency(op), name);
      expect_idle(name);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.hi_write, bus.lo_write, bus.busy, bus.req_ready} !== 4'b0001 ||
          bus.hi_data !== 32'h0 || bus.lo_data !== 32'h0) begin
         n_err++; $display("FAIL reset: got hw/lw/busy/rdy=%b hi=%h lo=%h state=%0d want 0001 0 0",
                           {bus.hi_write, bus.lo_write, bus.busy, bus.req_ready},
                           bus.hi_data, bus.lo_data, dbg_state);
      end
   endtask

   task automatic test_mt();
      do_op(3'd5, 32'h1234_5678, 32'h0, "mthi");
      do_op(3'd6, 32'hCAFE_F00D, 32'h0, "mtlo");
   endtask

   task automatic test_mul();
      do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg");
      do_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mult_min");
   endtask

   task automatic test_div();
      do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
      do_op(3'd4, 32'd100, 32'd0, "divu_zero");
      do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      do_op(3'd3, 32'hFFFF_FF9C, 32'd0, "div_zero_neg");
      do_op(3'd4, 32'hFFFF_FFFF, 32'd7, "divu_big");
   endtask

   task automatic test_nop();
      bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 32'h1; bus.req_b = 32'h1;
      @(posedge clk); #1 bus.req_op = 3'd7;
      @(posedge clk); #1 bus.req_valid = 1'b0;
      expect_idle("nop_reserved");
   endtask

   task automatic test_flush_div();
      exp_q.push_back(model(3'd4, 32'd1000, 32'd3));
      bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_a = 32'd1000; bus.req_b = 32'd3;
      @(posedge clk); #1 bus.req_valid = 1'b0;
      void'(exp_q.pop_front());
      repeat (10) @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk); #1 bus.flush = 1'b0;
      expect_idle("flush_div");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus.hi_write, bus.lo_write} !== 2'b00) begin
            n_err++; $display("FAIL flush_div late_strobe: got %b want 00",
                              {bus.hi_write, bus.lo_write});
         end
      end
      do_op(3'd6, 32'h0BAD_BEEF, 32'h0, "mtlo_after_flush");
   endtask

   task automatic test_flush_done_and_idle();
      bus.req_valid = 1'b1; bus.req_op = 3'd5; bus.req_a = 32'h5555_AAAA;
      @(posedge clk); #1 bus.req_valid = 1'b0; bus.flush = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.hi_write !== 1'b0) begin
         n_err++; $display("FAIL flush_done hw: got %b want 0", bus.hi_write);
      end
      @(posedge clk); #1 bus.flush = 1'b0;
      expect_idle("flush_done");
      bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_op = 3'd6; bus.req_a = 32'h1;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b0) begin
         n_err++; $display("FAIL flush_idle ready: got %b want 0", bus.req_ready);
      end
      @(posedge clk); #1 bus.flush = 1'b0; bus.req_valid = 1'b0;
      expect_idle("flush_idle");
   endtask

   task automatic test_reset_mid_op();
      bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_a = 32'd7; bus.req_b = 32'd9;
      @(posedge clk); #1 bus.req_valid = 1'b0;
      @(negedge clk) resetn = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      for (int k = 0; k < MUL_LAT + 2; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus.hi_write, bus.lo_write, bus.busy} !== 3'b000 || bus.hi_data !== 32'h0 ||
             bus.lo_data !== 32'h0) begin
            n_err++; $display("FAIL reset_mid k=%0d: got hw/lw/busy=%b hi=%h lo=%h want 000 0 0",
                              k, {bus.hi_write, bus.lo_write, bus.busy}, bus.hi_data, bus.lo_data);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(model(3'd1, 32'hFFFF_F000, 32'd5000));
      exp_q.push_back(model(3'd4, 32'd123456, 32'd789));
      bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_a = 32'hFFFF_F000; bus.req_b = 32'd5000;
      @(posedge clk); #1;
      bus.req_op = 3'd4; bus.req_a = 32'd123456; bus.req_b = 32'd789;
      expect_result(MUL_LAT + 1, "b2b_mult");
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.req_ready} !== 2'b01) begin
         n_err++; $display("FAIL b2b gap busy/rdy: got %b want 01", {bus.busy, bus.req_ready});
      end
      @(posedge clk); #1 bus.req_valid = 1'b0;
      expect_result(DIV_LAT, "b2b_divu");
      expect_idle("b2b_divu");
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(1, 6));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 5) == 0) b = 32'h0;
         else if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 20)) * (b[31] ? -1 : 1);
         do_op(op, a, b, "random");
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_a = 32'h0; bus.req_b = 32'h0;
      bus.flush = 1'b0;
      test_reset();
      test_mt();
      test_mul();
      test_div();
      test_nop();
      test_flush_div();
      test_flush_done_and_idle();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
